throw_turn_ctrl: RTL and testbench

Turn sequencer for the two-player throw game. Owns whose turn it is, launches the projectile into the vertical-trajectory block (`throw_flag`, `in_throw_flag`, `current_player`), and watches the returned `ypos` and the collision inputs to end each throw. It applies damage, swaps turns and declares the winner. Sits between the keyboard/button front end and the projectile/collision datapath, in the `clk60MHz` domain.

---
 rtl/variable_pkg.sv | 21 ++
 rtl/hp_counter.sv | 37 +++
 rtl/throw_turn_ctrl.sv | 176 +++++++++++++++++
 tb/tb_throw_turn_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/variable_pkg.sv
// Shared player encodings and turn-sequencer state type for the throw game.
package variable_pkg;

  localparam logic [1:0] PLAYER_NONE = 2'b00;
  localparam logic [1:0] PLAYER_1    = 2'b01;
  localparam logic [1:0] PLAYER_2    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    LAUNCH,
    FLIGHT,
    SETTLE,
    GAME_OVER
  } turn_state_t;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PLAYER_1) ? PLAYER_2 : PLAYER_1;
  endfunction

endpackage

// File: rtl/hp_counter.sv
// One player's health: reload, saturating damage, and a zero flag.
module hp_counter #(
  parameter int unsigned HP_INIT = 100,
  parameter int unsigned DAMAGE  = 20,
  parameter int unsigned W       = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         damage_i,
  output logic [W-1:0] hp_o,
  output logic         zero_o
);

  localparam logic [W-1:0] HP_INIT_C = W'(HP_INIT);
  localparam logic [W-1:0] DAMAGE_C  = W'(DAMAGE);

  logic [W-1:0] hp_q, hp_d;

  always_comb begin
    hp_d = hp_q;
    if (load_i) begin
      hp_d = HP_INIT_C;
    end else if (damage_i) begin
      hp_d = (hp_q >= DAMAGE_C) ? hp_q - DAMAGE_C : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hp_q <= HP_INIT_C;
    else         hp_q <= hp_d;
  end

  assign hp_o   = hp_q;
  assign zero_o = (hp_q == '0);

endmodule

// File: rtl/throw_turn_ctrl.sv
// Turn sequencer: accepts the active player's throw, launches, watches the
// flight for hit/landing/timeout, applies damage, swaps turns, picks a winner.
module throw_turn_ctrl
  import variable_pkg::*;
#(
  parameter int unsigned GROUND_Y       = 769,
  parameter int unsigned ARM_CYCLES     = 4,
  parameter int unsigned FLIGHT_TIMEOUT = 120_000_000,
  parameter int unsigned SETTLE_CYCLES  = 3_000_000,
  parameter int unsigned HP_INIT        = 100,
  parameter int unsigned DAMAGE         = 20
) (
  input  logic        clk60MHz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        throw_p1,
  input  logic        throw_p2,
  input  logic [11:0] ypos,
  input  logic        hit_p1,
  input  logic        hit_p2,
  output logic [1:0]  current_player,
  output logic        throw_flag,
  output logic        in_throw_flag,
  output logic        end_throw,
  output logic [6:0]  hp_p1,
  output logic [6:0]  hp_p2,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int unsigned CNT_MAX = (FLIGHT_TIMEOUT > SETTLE_CYCLES) ? FLIGHT_TIMEOUT
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX);

  localparam logic [CW-1:0] ARM_C          = CW'(ARM_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_LAST_C = CW'(FLIGHT_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST_C  = CW'(SETTLE_CYCLES - 1);
  localparam logic [11:0]   GROUND_C       = 12'(GROUND_Y);

  turn_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    player_q;
  logic [1:0]    winner_q;
  logic          throw_flag_q;
  logic          in_throw_q;
  logic          end_throw_q;
  logic          game_over_q;

  logic accept, opp_hit, landed, timed_out, flight_exit;
  logic hp_load, dmg_p1, dmg_p2, zero_p1, zero_p2;

  assign accept    = (player_q == PLAYER_1 && throw_p1) ||
                     (player_q == PLAYER_2 && throw_p2);
  // Only the opponent's sprite counts; a self-hit is ignored.
  assign opp_hit   = (player_q == PLAYER_1 && hit_p2) ||
                     (player_q == PLAYER_2 && hit_p1);
  assign landed    = (cnt_q >= ARM_C) && (ypos >= GROUND_C);
  assign timed_out = (cnt_q == TIMEOUT_LAST_C);
  assign flight_exit = opp_hit || landed || timed_out;

  assign dmg_p1 = (state_q == FLIGHT) && (player_q == PLAYER_2) && hit_p1;
  assign dmg_p2 = (state_q == FLIGHT) && (player_q == PLAYER_1) && hit_p2;

  always_comb begin
    hp_load = 1'b0;
    case (state_q)
      IDLE, GAME_OVER:              hp_load = start;
      TURN, LAUNCH, FLIGHT, SETTLE: hp_load = 1'b0;
      default:                      hp_load = 1'b1;
    endcase
  end

  hp_counter #(.HP_INIT(HP_INIT), .DAMAGE(DAMAGE), .W(7)) u_hp_p1 (
    .clk_i    (clk60MHz),
    .rst_ni   (rst_n),
    .load_i   (hp_load),
    .damage_i (dmg_p1),
    .hp_o     (hp_p1),
    .zero_o   (zero_p1)
  );

  hp_counter #(.HP_INIT(HP_INIT), .DAMAGE(DAMAGE), .W(7)) u_hp_p2 (
    .clk_i    (clk60MHz),
    .rst_ni   (rst_n),
    .load_i   (hp_load),
    .damage_i (dmg_p2),
    .hp_o     (hp_p2),
    .zero_o   (zero_p2)
  );

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      player_q     <= PLAYER_NONE;
      winner_q     <= PLAYER_NONE;
      throw_flag_q <= 1'b0;
      in_throw_q   <= 1'b0;
      end_throw_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      throw_flag_q <= 1'b0;
      end_throw_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= TURN;
            player_q <= PLAYER_1;
          end
        end
        TURN: begin
          if (accept) begin
            state_q      <= LAUNCH;
            throw_flag_q <= 1'b1;
            in_throw_q   <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q <= FLIGHT;
          cnt_q   <= '0;
        end
        FLIGHT: begin
          if (flight_exit) begin
            state_q     <= SETTLE;
            cnt_q       <= '0;
            in_throw_q  <= 1'b0;
            end_throw_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST_C) begin
            cnt_q <= '0;
            // Health settled on SETTLE entry, so the zero flags are final here.
            if (zero_p1 || zero_p2) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
              player_q    <= PLAYER_NONE;
              winner_q    <= zero_p2 ? PLAYER_1 : PLAYER_2;
            end else begin
              state_q  <= TURN;
              player_q <= other_player(player_q);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAME_OVER: begin
          if (start) begin
            state_q     <= TURN;
            player_q    <= PLAYER_1;
            game_over_q <= 1'b0;
            winner_q    <= PLAYER_NONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          player_q    <= PLAYER_NONE;
          winner_q    <= PLAYER_NONE;
          in_throw_q  <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign current_player = player_q;
  assign throw_flag     = throw_flag_q;
  assign in_throw_flag  = in_throw_q;
  assign end_throw      = end_throw_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_throw_turn_ctrl.sv
// Scoreboard bench: random games are played against a rule-level model that
// queues expected events; a monitor pops them whenever the DUT shows one.
module tb_throw_turn_ctrl;

  localparam int ARM = 4, TO = 60, SET = 8, GY = 769, HPI = 100, DMG = 20;
  localparam logic [1:0] P_NONE = 2'b00, P1 = 2'b01, P2 = 2'b10;
  localparam int M_LAND = 0, M_TO = 1, M_HIT = 2;

  logic        clk60MHz = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, throw_p1 = 1'b0, throw_p2 = 1'b0;
  logic        hit_p1 = 1'b0, hit_p2 = 1'b0;
  logic [11:0] ypos = 12'd769;
  logic [1:0]  current_player, winner;
  logic        throw_flag, in_throw_flag, end_throw, game_over;
  logic [6:0]  hp_p1, hp_p2;

  throw_turn_ctrl #(
    .GROUND_Y(GY), .ARM_CYCLES(ARM), .FLIGHT_TIMEOUT(TO),
    .SETTLE_CYCLES(SET), .HP_INIT(HPI), .DAMAGE(DMG)
  ) dut (
    .clk60MHz(clk60MHz), .rst_n(rst_n), .start(start),
    .throw_p1(throw_p1), .throw_p2(throw_p2), .ypos(ypos),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .current_player(current_player),
    .throw_flag(throw_flag), .in_throw_flag(in_throw_flag), .end_throw(end_throw),
    .hp_p1(hp_p1), .hp_p2(hp_p2), .game_over(game_over), .winner(winner)
  );

  always #5 clk60MHz = ~clk60MHz;

  int cyc = 0;
  always @(posedge clk60MHz) cyc <= cyc + 1;

  typedef enum int {EV_LAUNCH, EV_END, EV_TURN, EV_GO} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [1:0] pl;
    int         hp1;
    int         hp2;
    logic [1:0] win;
  } ev_t;

  ev_t expq[$];
  int  checks = 0, errors = 0;
  bit  mon_en = 1'b0;

  // Reference game state
  int         hp[1:2];
  logic [1:0] turn = P_NONE;
  int         tcyc = 0;

  task automatic push_ev(input ev_kind_t k, input int c, input logic [1:0] pl,
                         input logic [1:0] w);
    ev_t e;
    e.kind = k; e.cyc = c; e.pl = pl; e.hp1 = hp[1]; e.hp2 = hp[2]; e.win = w;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_ev(input ev_kind_t k);
    ev_t e;
    bit  ok;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s at cyc %0d: got event, required none", k.name(), cyc);
      return;
    end
    e  = expq.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc);
    case (k)
      EV_LAUNCH: ok &= in_throw_flag && (current_player == e.pl);
      EV_END:    ok &= !in_throw_flag && (current_player == e.pl) &&
                       (int'(hp_p1) == e.hp1) && (int'(hp_p2) == e.hp2);
      EV_TURN:   ok &= (current_player == e.pl) && !game_over && (winner == P_NONE) &&
                       (int'(hp_p1) == e.hp1) && (int'(hp_p2) == e.hp2);
      EV_GO:     ok &= (current_player == P_NONE) && (winner == e.win) &&
                       (int'(hp_p1) == e.hp1) && (int'(hp_p2) == e.hp2);
      default:   ok = 1'b0;
    endcase
    if (!ok) begin
      errors++;
      $display("FAIL event_%s: got kind=%s cyc=%0d cp=%0d hp=%0d/%0d win=%0d inthrow=%0b; required kind=%s cyc=%0d cp=%0d hp=%0d/%0d win=%0d",
               k.name(), k.name(), cyc, current_player, hp_p1, hp_p2, winner, in_throw_flag,
               e.kind.name(), e.cyc, e.pl, e.hp1, e.hp2, e.win);
    end
  endtask

  logic       go_prev = 1'b0;
  logic [1:0] cp_prev = P_NONE;
  always @(negedge clk60MHz) begin
    if (mon_en) begin
      if (throw_flag) check_ev(EV_LAUNCH);
      if (end_throw)  check_ev(EV_END);
      if (game_over && !go_prev)        check_ev(EV_GO);
      else if (current_player != cp_prev) check_ev(EV_TURN);
    end
    go_prev = game_over;
    cp_prev = current_player;
  end

  task automatic tick();
    @(negedge clk60MHz);
  endtask

  task automatic do_start();
    do tick(); while (cyc < tcyc);
    start  = 1'b1;
    hp[1]  = HPI;
    hp[2]  = HPI;
    turn   = P1;
    tcyc   = cyc + 1;
    push_ev(EV_TURN, cyc + 1, P1, P_NONE);
    tick();
    start = 1'b0;
  endtask

  task automatic play_throw(input int mode);
    logic [1:0] opp;
    int         c, k, kx, ce;
    bit         ohit, exit_now;
    opp = (turn == P1) ? P2 : P1;
    kx  = (mode == M_LAND) ? $urandom_range(ARM, 40) : $urandom_range(0, 30);
    do tick(); while (cyc < tcyc);
    // Inactive player's presses while in TURN must be dropped.
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      if (turn == P1) throw_p2 = 1'b1; else throw_p1 = 1'b1;
      tick();
      throw_p1 = 1'b0; throw_p2 = 1'b0;
    end
    if (turn == P1) throw_p1 = 1'b1; else throw_p2 = 1'b1;
    if ($urandom_range(0, 2) == 0) begin throw_p1 = 1'b1; throw_p2 = 1'b1; end
    c = cyc;
    push_ev(EV_LAUNCH, c + 1, turn, P_NONE);
    tick();
    throw_p1 = 1'b0; throw_p2 = 1'b0;
    ypos = 12'd454;
    k = 0;
    forever begin
      tick();
      if (k < ARM)
        ypos = (mode == M_LAND || $urandom_range(0, 1) == 1) ? 12'(GY) : 12'd454;
      else if (mode == M_LAND && k >= kx)
        ypos = 12'(GY + $urandom_range(0, 30));
      else if (mode == M_HIT && k == kx)
        ypos = 12'($urandom_range(300, GY + 30));
      else
        ypos = 12'($urandom_range(300, GY - 1));
      ohit = (mode == M_HIT) && (k == kx);
      if (turn == P1) begin hit_p2 = ohit; hit_p1 = ($urandom_range(0, 3) == 0); end
      else            begin hit_p1 = ohit; hit_p2 = ($urandom_range(0, 3) == 0); end
      start = ($urandom_range(0, 15) == 0);
      exit_now = ohit || (k >= ARM && int'(ypos) >= GY) || (k == TO - 1);
      if (exit_now) begin
        if (ohit) hp[opp] = (hp[opp] >= DMG) ? hp[opp] - DMG : 0;
        push_ev(EV_END, cyc + 1, turn, P_NONE);
        break;
      end
      k++;
    end
    tick();
    hit_p1 = 1'b0; hit_p2 = 1'b0; start = 1'b0; ypos = 12'(GY);
    ce   = cyc;
    tcyc = ce + SET;
    if (hp[1] == 0 || hp[2] == 0) begin
      push_ev(EV_GO, tcyc, P_NONE, (hp[2] == 0) ? P1 : P2);
      turn = P_NONE;
    end else begin
      turn = opp;
      push_ev(EV_TURN, tcyc, opp, P_NONE);
    end
  endtask

  function automatic int pick_mode();
    int r;
    r = $urandom_range(0, 9);
    return (r < 6) ? M_HIT : (r < 9) ? M_LAND : M_TO;
  endfunction

  initial begin
    int n;
    hp[1] = HPI; hp[2] = HPI;
    repeat (2) tick();
    chk("reset_player", current_player, P_NONE);
    chk("reset_hp1", hp_p1, HPI);
    chk("reset_hp2", hp_p2, HPI);
    chk("reset_flags", {throw_flag, in_throw_flag, end_throw, game_over}, 0);
    chk("reset_winner", winner, P_NONE);
    rst_n = 1'b1;
    mon_en = 1'b1;

    do_start();
    n = 0;
    while (turn != P_NONE && n < 200) begin
      play_throw((n == 0) ? M_LAND : (n == 1) ? M_TO : pick_mode());
      n++;
    end
    chk("game_ended", int'(turn == P_NONE), 1);

    do_start();
    repeat (3) play_throw(pick_mode());
    for (int i = 0; i < 100 && (expq.size() != 0 || cyc < tcyc); i++) tick();
    chk("queue_drained", expq.size(), 0);

    mon_en = 1'b0;
    if (turn == P1) throw_p1 = 1'b1; else throw_p2 = 1'b1;
    tick();
    throw_p1 = 1'b0; throw_p2 = 1'b0; ypos = 12'd454;
    repeat (5) tick();
    chk("midflight_inthrow", in_throw_flag, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_player", current_player, P_NONE);
    chk("async_rst_inthrow", in_throw_flag, 0);
    chk("async_rst_hp", {25'd0, hp_p1, hp_p2}, (HPI << 7) | HPI);
    chk("async_rst_flags", {throw_flag, end_throw, game_over, winner}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
